// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator request front end.
// Direction encoding matches the controller's direction output.
package elevator_pkg;

  localparam int DEF_N_FLOORS        = 4;
  localparam int DEF_FLOOR_BITS      = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    HELD,
    RELEASING
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button path: two-flop synchroniser, debounce FSM,
// registered one-cycle press pulse per accepted press.
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          s_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = ARMING;
          cnt_d   = CW'(1);
        end
      end
      ARMING: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s_q) begin
          state_d = RELEASING;
          cnt_d   = CW'(1);
        end
      end
      RELEASING: begin
        if (s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/elevator_call_latch.sv
// Debounces car/hall buttons and latches pending requests until the
// controller opens the door at that floor in the matching direction.
module elevator_call_latch
  import elevator_pkg::*;
#(
  parameter int N_FLOORS        = DEF_N_FLOORS,
  parameter int FLOOR_BITS      = DEF_FLOOR_BITS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_FLOORS-1:0]   btn_inside,
  input  logic [N_FLOORS-1:0]   btn_up,
  input  logic [N_FLOORS-1:0]   btn_down,
  input  logic [FLOOR_BITS-1:0] current_floor,
  input  logic                  door_open,
  input  logic                  direction,
  output logic [N_FLOORS-1:0]   inside_req,
  output logic [N_FLOORS-1:0]   up_call,
  output logic [N_FLOORS-1:0]   down_call,
  output logic                  any_pending
);

  logic [N_FLOORS-1:0] in_set, up_set, dn_set;
  logic [N_FLOORS-1:0] at_f;
  logic [N_FLOORS-1:0] inside_q, inside_d;
  logic [N_FLOORS-1:0] up_q, up_d;
  logic [N_FLOORS-1:0] down_q, down_d;
  logic                any_q, any_d;

  // No up button on the top floor, no down button on the ground floor
  logic unused_btn;
  assign unused_btn = btn_up[N_FLOORS-1] ^ btn_down[0];

  for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in (
      .clk(clk), .rst_n(rst_n),
      .btn(btn_inside[f]), .press_pulse(in_set[f])
    );
    if (f < N_FLOORS - 1) begin : g_up
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_up[f]), .press_pulse(up_set[f])
      );
    end else begin : g_up_off
      assign up_set[f] = 1'b0;
    end
    if (f > 0) begin : g_dn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_down[f]), .press_pulse(dn_set[f])
      );
    end else begin : g_dn_off
      assign dn_set[f] = 1'b0;
    end
  end

  always_comb begin
    at_f = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      at_f[f] = door_open && (current_floor == FLOOR_BITS'(f));
    end
    inside_d = (inside_q | in_set) & ~at_f;
    up_d     = (up_q | up_set)
             & ~(at_f & {N_FLOORS{direction == DIR_UP}});
    down_d   = (down_q | dn_set)
             & ~(at_f & {N_FLOORS{direction == DIR_DOWN}});
    any_d    = |{inside_d, up_d, down_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_q <= '0;
      up_q     <= '0;
      down_q   <= '0;
      any_q    <= 1'b0;
    end else begin
      inside_q <= inside_d;
      up_q     <= up_d;
      down_q   <= down_d;
      any_q    <= any_d;
    end
  end

  assign inside_req  = inside_q;
  assign up_call     = up_q;
  assign down_call   = down_q;
  assign any_pending = any_q;

endmodule

// File: doc/elevator_call_latch.md
Name: elevator_call_latch

Overview:
- Front-end request stage directly upstream of the elevator controller.
- Takes raw hall and car push-button inputs. Each input is synchronised and debounced, and each debounced press is latched as a pending request.
- Drives the controller's inside_req, up_call and down_call vectors.
- Clears a pending request when the controller services it: door open at that floor, in the matching direction. The latched vectors also serve as button-lamp drives.

Parameters:
- N_FLOORS, 4: number of floors; vector width of all button and request ports.
- FLOOR_BITS, 2: width of current_floor; must satisfy 2**FLOOR_BITS >= N_FLOORS.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a press or a release; legal range is >= 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_inside  in  N_FLOORS  raw car buttons, asynchronous, active-high.
- btn_up  in  N_FLOORS  raw hall up buttons; bit N_FLOORS-1 is ignored.
- btn_down  in  N_FLOORS  raw hall down buttons; bit 0 is ignored.
- current_floor  in  FLOOR_BITS  floor reported by the controller.
- door_open  in  1  controller door-open status.
- direction  in  1  controller direction: 1 = up, 0 = down.
- inside_req  out  N_FLOORS  pending car requests (registered).
- up_call  out  N_FLOORS  pending hall up calls (registered).
- down_call  out  N_FLOORS  pending hall down calls (registered).
- any_pending  out  1  OR of all three request vectors (registered).

Behaviour:
- Clocking and reset:
  - Single clock. rst_n is asynchronous active-low and is fixed as such.
  - While rst_n=0, all outputs are 0, every synchroniser flop is 0, every debouncer is IDLE with its counter at 0.
  - Reset asserted mid-debounce or with requests pending clears all of this immediately, without waiting for a clock edge.
- Per-button path (3*N_FLOORS instances; ignored bits are tied off, so up_call[N-1] and down_call[0] are constant 0):
  - Two-flop synchroniser producing s.
  - Debounce FSM states: IDLE, ARMING, HELD, RELEASING. Counter width is clog2(DEBOUNCE_CYCLES+1).
  - IDLE: s=1 -> ARMING with cnt=1.
  - ARMING: s=0 -> IDLE with cnt=0. s=1 with cnt=DEBOUNCE_CYCLES-1 -> HELD and emit a one-cycle press pulse. Otherwise cnt+1.
  - HELD: s=0 -> RELEASING with cnt=1.
  - RELEASING: s=1 -> HELD with cnt=0. s=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt+1.
  - Exactly one press pulse per accepted press. A held button never re-fires.
- Latency:
  - Raw input held high from before edge 1 -> pending bit reads 1 after edge DEBOUNCE_CYCLES+3 and 0 before it (2 synchroniser edges + DEBOUNCE_CYCLES counting edges + 1 latch edge).
  - With the default of 4, that is edge 7.
- Latch, per bit f:
  - Set: press pulse for f -> next = 1.
  - Clear, evaluated on the registered inputs each edge, with at_f = door_open && current_floor==f:
    - inside_req[f] clears when at_f.
    - up_call[f] clears when at_f && direction==1.
    - down_call[f] clears when at_f && direction==0.
  - Simultaneous set and clear on the same bit: clear wins.
  - current_floor >= N_FLOORS matches no bit.
- any_pending: registered OR of the next-state values of all three vectors, so it is coherent with the vectors on the same edge.
- Timing: no combinational path from any input to any output.

Decomposition:
- Shared package elevator_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Debounce state typedef: IDLE, ARMING, HELD, RELEASING.
  - Default constants N_FLOORS, FLOOR_BITS, DEBOUNCE_CYCLES.
- One sub-module, btn_debounce:
  - Single-bit synchroniser + FSM + counter, output press_pulse.
  - Generated 3*N_FLOORS times, minus the two ignored hall bits.
- Latch and clear logic stays in elevator_call_latch.

Test Plan (N_FLOORS=4, DEBOUNCE_CYCLES=4):
- btn_down=4'b0100 held 12 cycles, then released -> down_call=4'b0100 from edge 7, any_pending=1, remains set after release; exactly one press pulse observed.
- btn_inside[0] high for 3 cycles, then low -> inside_req stays 4'b0000 for 20 cycles.
- down_call=4'b0100 and up_call=4'b0100 pending; drive current_floor=2, door_open=1, direction=0 -> next edge down_call=0 and up_call=4'b0100. Then direction=1 -> up_call=0 and any_pending=0.
- btn_up=4'b1000 and btn_down=4'b0001 held 20 cycles -> up_call=0, down_call=0, any_pending=0 throughout.
- btn_inside[1] held while current_floor=1, door_open=1 -> inside_req[1] never observed 1 (clear wins). Then close the door with the button still held -> stays 0. Release for >=4 cycles and repress -> sets 7 edges after the repress.
- inside_req=4'b1010 pending and btn_up[0] in ARMING; pull rst_n low mid-cycle -> all outputs 0 before the next edge. After rst_n is released with btn_up[0] held, up_call[0] sets only after a full new DEBOUNCE_CYCLES+3 edges.
